// File: rtl/ledsuit_mem_pkg.sv
// Shared constants and helpers for the LED suit memory subsystem.
// This package is imported by the BRAM arbiter and its round-robin selector.
package ledsuit_mem_pkg;

  localparam int LED_MEM_ADDR_WIDTH = 13;
  localparam int LED_MEM_DATA_WIDTH = 8;

  // Start of each strip's pixel block inside the shared BRAM
  localparam int STRIP1_BASE_ADDRESS = 0;
  localparam int STRIP2_BASE_ADDRESS = 600;

  // Increments a round-robin index and wraps it back to 0 at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: the first requester at or after ptr wins.
// It is kept generic so that a write-side arbiter can reuse it.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] winner_o
);

  logic             found;
  int               sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path leaves a latch.
    gnt_o    = '0;
    winner_o = '0;
    found    = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= N) sum = sum - N;
      idx = IDX_W'(sum);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        winner_o   = idx;
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter that shares one read-only BRAM port among NUM_PORTS strip drivers.
// Each read carries a one-hot tag, so the data returns only to the port that issued it.
module bram_read_arbiter
  import ledsuit_mem_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = LED_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = LED_MEM_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            mem_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_dout
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      winner;
  logic [NUM_PORTS-1:0]  sel_gnt;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_PORTS-1:0]  tag_q [READ_LATENCY];

  rr_select #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .gnt_o    (sel_gnt),
    .winner_o (winner)
  );

  // The grant is one-hot, so an OR of the masked addresses selects the winner's address.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_gnt[i]) win_addr = win_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign gnt      = rst ? '0 : sel_gnt;
  assign mem_en   = |gnt;
  assign mem_addr = mem_en ? win_addr : addr_q;
  assign ptr_d    = mem_en ? IDX_W'(rr_next(32'(winner), NUM_PORTS)) : ptr_q;

  assign rd_valid = rst ? '0 : tag_q[READ_LATENCY-1];
  assign rd_data  = mem_dout;

  // NOTE: non-blocking assignments here, so each shift stage sees the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      addr_q <= '0;
      // NOTE: the tag pipeline is a small shift register, so it is reset; otherwise tags in flight would survive the reset.
      for (int k = 0; k < READ_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      addr_q   <= mem_addr;
      tag_q[0] <= gnt;
      for (int k = 1; k < READ_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Scoreboard bench: three arbiters with read latencies of 1, 2 and 3 share the same request stimulus.
// Directed vectors carry hand-computed grants; a monitor matches every rd_valid against a queue of expected reads.
module tb_bram_read_arbiter;

  localparam int NP = 4;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int NI = 3;

  typedef struct {
    int            due;
    logic [NP-1:0] v;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req = '0;
  logic [AW-1:0] addr_v [NP];
  logic [NP*AW-1:0] req_addr;

  logic [NP-1:0] gnt_a    [NI];
  logic [NP-1:0] rdv_a    [NI];
  logic [DW-1:0] rdd_a    [NI];
  logic [DW-1:0] dout_a   [NI];
  logic          mem_en_a [NI];
  logic [AW-1:0] mem_addr_a [NI];

  exp_t          exp_q [NI][$];
  exp_t          mon_e;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            mon_on = 1'b0;
  logic [AW-1:0] last_addr = '0;

  // BRAM contents: the data byte is the low address byte XOR 0xA0, so address 5 holds 0xA5.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA0;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_addr = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = g + 1;
    logic [DW-1:0] d_pipe [L];

    bram_read_arbiter #(
      .NUM_PORTS    (NP),
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (L)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt_a[g]),
      .rd_valid (rdv_a[g]),
      .rd_data  (rdd_a[g]),
      .mem_en   (mem_en_a[g]),
      .mem_addr (mem_addr_a[g]),
      .mem_dout (dout_a[g])
    );

    always @(posedge clk) begin
      d_pipe[0] <= mem_val(mem_addr_a[g]);
      for (int k = 1; k < L; k++) d_pipe[k] <= d_pipe[k-1];
    end
    assign dout_a[g] = d_pipe[L-1];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Applies one cycle of requests, checks the combinational outputs and queues the expected reads.
  task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] eg, input string nm,
                       input bit push = 1'b1);
    logic [AW-1:0] ea;
    exp_t          e;
    req = r;
    @(negedge clk);
    ea = last_addr;
    for (int i = 0; i < NP; i++) if (eg[i]) ea = addr_v[i];
    for (int j = 0; j < NI; j++) begin
      check($sformatf("%s L%0d gnt", nm, j + 1), 32'(gnt_a[j]), 32'(eg));
      check($sformatf("%s L%0d mem_en", nm, j + 1), 32'(mem_en_a[j]), 32'(|eg));
      check($sformatf("%s L%0d mem_addr", nm, j + 1), 32'(mem_addr_a[j]), 32'(ea));
      if (eg != '0 && push) begin
        e.due = cyc + j + 1;
        e.v   = eg;
        e.d   = mem_val(ea);
        exp_q[j].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    last_addr = rst ? '0 : ea;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int j = 0; j < NI; j++) begin
        if (exp_q[j].size() > 0 && exp_q[j][0].due == cyc) begin
          mon_e = exp_q[j].pop_front();
          check($sformatf("L%0d rd_valid", j + 1), 32'(rdv_a[j]), 32'(mon_e.v));
          check($sformatf("L%0d rd_data", j + 1), 32'(rdd_a[j]), 32'(mon_e.d));
        end else begin
          check($sformatf("L%0d rd_valid quiet", j + 1), 32'(rdv_a[j]), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NP; i++) addr_v[i] = '0;
    rst = 1'b1;
    req = '1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Requests asserted during reset are ignored
    drive(4'b1111, 4'b0000, "in reset");
    rst = 1'b0;
    drive(4'b0000, 4'b0000, "reset state");

    // Single requester, data 0xA5 one cycle later on the latency-1 instance
    addr_v[0] = 13'h005;
    drive(4'b0001, 4'b0001, "single");
    repeat (4) drive(4'b0000, 4'b0000, "single drain");

    // Return the pointer to 0 before the contention run
    rst = 1'b1;
    drive(4'b1011, 4'b0000, "rst pulse");
    rst = 1'b0;

    addr_v[0] = 13'h010;
    addr_v[1] = 13'h021;
    addr_v[3] = 13'h033;
    drive(4'b1011, 4'b0001, "contend0");
    drive(4'b1011, 4'b0010, "contend1");
    drive(4'b1011, 4'b1000, "contend2");
    drive(4'b1011, 4'b0001, "contend3");
    drive(4'b1011, 4'b0010, "contend4");
    drive(4'b1011, 4'b1000, "contend5");
    repeat (4) drive(4'b0000, 4'b0000, "contend drain");

    // Back-to-back reads from port 2 at the start of strip 2
    addr_v[2] = 13'd600;
    drive(4'b0100, 4'b0100, "b2b600");
    addr_v[2] = 13'd601;
    drive(4'b0100, 4'b0100, "b2b601");
    addr_v[2] = 13'd602;
    drive(4'b0100, 4'b0100, "b2b602");
    repeat (4) drive(4'b0000, 4'b0000, "b2b drain");

    // Pointer is 3: port 3 wins first, then wraps to port 0, leaving the pointer at 1
    addr_v[0] = 13'h100;
    addr_v[3] = 13'h1FF;
    drive(4'b1001, 4'b1000, "wrap3");
    drive(4'b1001, 4'b0001, "wrap0");
    drive(4'b0101, 4'b0100, "ptr1");

    // Pointer is 3: port 0 wins, then port 1 drops its request before being granted
    addr_v[1] = 13'h0C4;
    drive(4'b0011, 4'b0001, "cancel grant");
    drive(4'b0000, 4'b0000, "cancel drop");
    repeat (3) drive(4'b0000, 4'b0000, "cancel drain");

    // Pointer is 1: port 1 is granted, then reset lands while its read is in flight
    addr_v[1] = 13'h0AB;
    drive(4'b0010, 4'b0010, "pre-reset grant", 1'b0);
    rst = 1'b1;
    drive(4'b0010, 4'b0000, "reset mid-flight");
    rst = 1'b0;
    drive(4'b0000, 4'b0000, "post-reset");
    drive(4'b0000, 4'b0000, "post-reset");
    drive(4'b1111, 4'b0001, "ptr after reset");

    repeat (20) drive(4'b0000, 4'b0000, "idle");

    for (int j = 0; j < NI; j++) check($sformatf("L%0d reads outstanding", j + 1), 32'(exp_q[j].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
